// File: rtl/rpn_pkg.sv
// Shared RPN calculator types: datapath word and default operand-stack depth.
// No logic; consumed by stack_controller, rpn_stack and the ALU.
package rpn_pkg;
    localparam int WORD_W      = 16;
    localparam int STACK_DEPTH = 16;

    typedef logic [WORD_W-1:0] word_t;

    // One command per cycle, listed in decreasing priority.
    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_CLR,
        CMD_REPL,
        CMD_PUSH_UF,
        CMD_PUSH,
        CMD_OVF,
        CMD_POP,
        CMD_UF
    } cmd_e;
endpackage

// File: rtl/rpn_stack_if.sv
// Operand stack port bundle: push/pop/flush requests in, top entries and status out.
// No handshake: requests are resolved in the cycle presented.
interface rpn_stack_if #(
    parameter int WIDTH = rpn_pkg::WORD_W,
    parameter int DEPTH = rpn_pkg::STACK_DEPTH
);
    logic [WIDTH-1:0]        din;
    logic                    wen;
    logic                    pop;
    logic                    clr;
    logic                    err_clr;
    logic [WIDTH-1:0]        tos;
    logic [WIDTH-1:0]        nos;
    logic [$clog2(DEPTH):0]  depth;
    logic                    empty;
    logic                    full;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output din, wen, pop, clr, err_clr,
        input  tos, nos, depth, empty, full, overflow, underflow
    );

    modport slave (
        input  din, wen, pop, clr, err_clr,
        output tos, nos, depth, empty, full, overflow, underflow
    );
endinterface

// File: rtl/rpn_stack_mem.sv
// Stack storage: one synchronous write port, two combinational read ports; no reset.
// Write lands on the clock edge; reads are zero-latency; never stalls.
module rpn_stack_mem #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdat,
    input  logic [AW-1:0]    raddr0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdat0,
    output logic [WIDTH-1:0] rdat1
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
    end

    assign rdat0 = mem[raddr0];
    assign rdat1 = mem[raddr1];
endmodule

// File: rtl/rpn_stack.sv
// RPN operand stack: push/pop/replace-top/flush, outputs valid right after the edge; no stall,
// rejected requests raise overflow/underflow. RPN_STACK_STICKY_ERR_EN makes the flags sticky.
module rpn_stack
    import rpn_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = STACK_DEPTH
) (
    input logic        clk,
    input logic        rst_n,
    rpn_stack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    sp;
    logic [PW-1:0]    sp_nxt;
    cmd_e             cmd;
    logic             is_empty;
    logic             is_full;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    nos_idx;
    logic [WIDTH-1:0] rd_top;
    logic [WIDTH-1:0] rd_nos;
    logic             ovf_evt;
    logic             unf_evt;
    logic             overflow_q;
    logic             underflow_q;

    assign is_empty = (sp == '0);
    assign is_full  = (sp == PW'(DEPTH));
    assign top_idx  = AW'(sp - PW'(1));
    assign nos_idx  = AW'(sp - PW'(2));

    always_comb begin
        cmd = CMD_HOLD;
        if (bus.clr)                          cmd = CMD_CLR;
        else if (bus.wen && bus.pop && !is_empty) cmd = CMD_REPL;
        else if (bus.wen && bus.pop)          cmd = CMD_PUSH_UF;
        else if (bus.wen && !is_full)         cmd = CMD_PUSH;
        else if (bus.wen)                     cmd = CMD_OVF;
        else if (bus.pop && !is_empty)        cmd = CMD_POP;
        else if (bus.pop)                     cmd = CMD_UF;
    end

    always_comb begin
        sp_nxt  = sp;
        we      = 1'b0;
        waddr   = AW'(sp);
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        case (cmd)
            CMD_CLR:     sp_nxt = '0;
            CMD_REPL: begin
                we    = 1'b1;
                waddr = top_idx;
            end
            CMD_PUSH_UF: begin
                we      = 1'b1;
                waddr   = '0;
                sp_nxt  = PW'(1);
                unf_evt = 1'b1;
            end
            CMD_PUSH: begin
                we     = 1'b1;
                sp_nxt = sp + PW'(1);
            end
            CMD_OVF:     ovf_evt = 1'b1;
            CMD_POP:     sp_nxt  = sp - PW'(1);
            CMD_UF:      unf_evt = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp          <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp <= sp_nxt;
`ifdef RPN_STACK_STICKY_ERR_EN
            // A fresh error beats err_clr arriving in the same cycle.
            overflow_q  <= ovf_evt | (overflow_q  & ~bus.err_clr & ~bus.clr);
            underflow_q <= unf_evt | (underflow_q & ~bus.err_clr & ~bus.clr);
`else
            overflow_q  <= ovf_evt;
            underflow_q <= unf_evt;
`endif
        end
    end

`ifndef RPN_STACK_STICKY_ERR_EN
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
`endif

    // Reset discards the same-cycle command, including its write.
    rpn_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk    (clk),
        .we     (we & rst_n),
        .waddr  (waddr),
        .wdat   (bus.din),
        .raddr0 (top_idx),
        .raddr1 (nos_idx),
        .rdat0  (rd_top),
        .rdat1  (rd_nos)
    );

    assign bus.tos       = is_empty ? '0 : rd_top;
    assign bus.nos       = (sp < PW'(2)) ? '0 : rd_nos;
    assign bus.depth     = sp;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_rpn_stack.sv
// Bench for rpn_stack: directed vector table, hand-written corner sequences,
// then random traffic against a queue-based reference model.
module tb_rpn_stack;
    import rpn_pkg::*;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int DW = $clog2(D) + 1;
`ifdef RPN_STACK_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rpn_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

    rpn_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic          wen, pop, clr, err_clr;
        logic [W-1:0]  din;
        logic [W-1:0]  tos, nos;
        logic [DW-1:0] depth;
        logic          empty, full, ovf, unf;
    } vec_t;

    int nvec = 0;
    int nerr = 0;

    // Reference model: back of the queue is the top of stack.
    word_t m_q[$];
    bit    m_ovf, m_unf;

    function automatic vec_t mk(input logic w, p, c, ec, input int din,
                                input int tos, nos, depth,
                                input logic e, f, o, u);
        vec_t v;
        v.wen = w; v.pop = p; v.clr = c; v.err_clr = ec;
        v.din = W'(din); v.tos = W'(tos); v.nos = W'(nos); v.depth = DW'(depth);
        v.empty = e; v.full = f; v.ovf = o; v.unf = u;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] et, en,
                         input logic [DW-1:0] ed, input logic ee, ef, eo, eu);
        nvec++;
        if (bus.tos !== et || bus.nos !== en || bus.depth !== ed || bus.empty !== ee ||
            bus.full !== ef || bus.overflow !== eo || bus.underflow !== eu) begin
            nerr++;
            $display("FAIL %s: got tos=%0d nos=%0d depth=%0d empty=%0b full=%0b ovf=%0b unf=%0b; want tos=%0d nos=%0d depth=%0d empty=%0b full=%0b ovf=%0b unf=%0b",
                     name, bus.tos, bus.nos, bus.depth, bus.empty, bus.full, bus.overflow,
                     bus.underflow, et, en, ed, ee, ef, eo, eu);
        end
    endtask

    task automatic drive(input logic w, p, c, ec, input logic [W-1:0] d);
        bus.wen = w; bus.pop = p; bus.clr = c; bus.err_clr = ec; bus.din = d;
        @(posedge clk);
        #1;
        bus.wen = 1'b0; bus.pop = 1'b0; bus.clr = 1'b0; bus.err_clr = 1'b0;
    endtask

    task automatic model_step(input logic w, p, c, ec, input word_t d);
        bit oe, ue;
        oe = 1'b0; ue = 1'b0;
        if (c) m_q.delete();
        else if (w && p && m_q.size() > 0) m_q[m_q.size()-1] = d;
        else if (w && p) begin m_q.push_back(d); ue = 1'b1; end
        else if (w && m_q.size() < D) m_q.push_back(d);
        else if (w) oe = 1'b1;
        else if (p && m_q.size() > 0) void'(m_q.pop_back());
        else if (p) ue = 1'b1;
        if (STICKY) begin
            m_ovf = oe || (m_ovf && !ec && !c);
            m_unf = ue || (m_unf && !ec && !c);
        end else begin
            m_ovf = oe;
            m_unf = ue;
        end
    endtask

    task automatic check_model(input string name);
        int n;
        n = m_q.size();
        check(name, (n > 0) ? m_q[n-1] : '0, (n > 1) ? m_q[n-2] : '0, DW'(n),
              n == 0, n == D, m_ovf, m_unf);
    endtask

    vec_t tbl[15];

    initial begin
        bus.wen = 1'b0; bus.pop = 1'b0; bus.clr = 1'b0; bus.err_clr = 1'b0; bus.din = '0;

        //              w  p  c  ec din   tos nos dep e  f  o  u
        tbl[0]  = mk(1, 0, 0, 0, 10,  10, 0,  1,  0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 20,  20, 10, 2,  0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0,   10, 0,  1,  0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0,   0,  0,  0,  1, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0,   0,  0,  0,  1, 0, 0, 1);
        tbl[5]  = mk(0, 0, 0, 1, 0,   0,  0,  0,  1, 0, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 10,  10, 0,  1,  0, 0, 0, 0);
        tbl[7]  = mk(1, 0, 0, 0, 20,  20, 10, 2,  0, 0, 0, 0);
        tbl[8]  = mk(1, 1, 0, 0, 30,  30, 10, 2,  0, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 0, 5,   5,  30, 3,  0, 0, 0, 0);
        tbl[10] = mk(1, 0, 1, 0, 77,  0,  0,  0,  1, 0, 0, 0);
        tbl[11] = mk(1, 1, 0, 0, 42,  42, 0,  1,  0, 0, 0, 1);
        tbl[12] = mk(0, 1, 0, 1, 0,   0,  0,  0,  1, 0, 0, 0);
        tbl[13] = mk(0, 1, 0, 1, 0,   0,  0,  0,  1, 0, 0, 1);
        tbl[14] = mk(0, 0, 0, 1, 0,   0,  0,  0,  1, 0, 0, 0);

        // Reset
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("reset", '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].wen, tbl[i].pop, tbl[i].clr, tbl[i].err_clr, tbl[i].din);
            check($sformatf("tbl%0d", i), tbl[i].tos, tbl[i].nos, tbl[i].depth,
                  tbl[i].empty, tbl[i].full, tbl[i].ovf, tbl[i].unf);
        end

        // Fill to capacity, overflow, then replace-top while full
        for (int i = 1; i <= D; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, W'(i));
            check($sformatf("fill%0d", i), W'(i), W'(i - 1), DW'(i), 1'b0, i == D, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, W'(99));
        check("overflow", W'(16), W'(15), DW'(16), 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, W'(7));
        check("repl_full", W'(7), W'(15), DW'(16), 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset asserted during a push
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, W'(55));
        check("reset_mid", '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Error flag lifetime
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("unf_set", '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
            check($sformatf("unf_idle%0d", i), '0, '0, '0, 1'b1, 1'b0, 1'b0, STICKY);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("unf_errclr", '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random traffic against the reference model
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b1;
        m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic w, p, c, ec;
            word_t d;
            int pw, pp;
            pw = (i < 1500) ? 60 : 35;
            pp = (i < 1500) ? 40 : 60;
            w  = ($urandom_range(99) < pw);
            p  = ($urandom_range(99) < pp);
            c  = ($urandom_range(99) < 2);
            ec = ($urandom_range(99) < 15);
            d  = W'($urandom);
            drive(w, p, c, ec, d);
            model_step(w, p, c, ec, d);
            check_model($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
